// File: rtl/shift_ctrl_pkg.sv
// Shared types and sizing helpers for the serial shift sequencer.
// Used by shift_seq_ctrl (optional parity build: SHIFT_PARITY_EN).
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } shift_state_t;

    // Counter must reach WIDTH+1 (parity build) without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Right-shift register with parallel load: serial data enters at the MSB,
// bit0 is the next bit to leave. Load takes priority over shift.
module shift_reg_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_data;
        end else if (shift) begin
            data_d = {ser_in, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign par_out = data_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex serial shift sequencer: parallel word in, serial out/in, parallel word out.
// Define SHIFT_PARITY_EN to append an even-parity bit and check the received parity.
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    input  logic             ser_in,
    output logic             shift_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             parity_err
);

    localparam int CNT_W = cnt_width(WIDTH);
`ifdef SHIFT_PARITY_EN
    localparam int NSHIFT = WIDTH + 1;
`else
    localparam int NSHIFT = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSHIFT - 1);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(WIDTH);

    shift_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tx_word;
    logic [WIDTH-1:0] rx_word;
    logic             accept;
    logic             data_phase;
    logic             tx_unused;

    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign data_phase = (state_q == SHIFT) && (cnt_q < DATA_CNT);
    // Only bit0 of the transmit register is ever driven onto the line.
    assign tx_unused  = ^tx_word[WIDTH-1:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SHIFT_PARITY_EN
    logic tx_par_q, tx_par_d;
    logic parity_err_q, parity_err_d;

    // Transmit parity is latched at accept because the tx register drains during shifting.
    always_comb begin
        tx_par_d     = accept ? ^in_data : tx_par_q;
        parity_err_d = parity_err_q;
        if (state_q == SHIFT && !data_phase) begin
            parity_err_d = ser_in ^ (^rx_word);
        end else if (state_q == HOLD && out_ready) begin
            parity_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_par_q     <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            tx_par_q     <= tx_par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        shift_en  = (state_q == SHIFT);
        busy      = (state_q != IDLE);
        out_valid = (state_q == HOLD);
        ser_out   = IDLE_LEVEL;
        if (state_q == SHIFT) begin
`ifdef SHIFT_PARITY_EN
            ser_out = data_phase ? tx_word[0] : tx_par_q;
`else
            ser_out = tx_word[0];
`endif
        end
    end

    assign out_data = rx_word;

    shift_reg_core #(.WIDTH(WIDTH)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (in_data),
        .shift     (state_q == SHIFT),
        .ser_in    (1'b0),
        .par_out   (tx_word)
    );

    shift_reg_core #(.WIDTH(WIDTH)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data ({WIDTH{1'b0}}),
        .shift     (data_phase),
        .ser_in    (ser_in),
        .par_out   (rx_word)
    );

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl against a word-level transfer model.
// Parity cases are exercised when SHIFT_PARITY_EN is defined.
module tb_shift_seq_ctrl;

    localparam int   WIDTH      = 8;
    localparam logic IDLE_LEVEL = 1'b1;
`ifdef SHIFT_PARITY_EN
    localparam int NSHIFT = WIDTH + 1;
`else
    localparam int NSHIFT = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_in;
    logic             shift_en;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             parity_err;

    logic serInDrv;
    logic loopMode;
    int   checkCount = 0;
    int   errorCount = 0;

    assign ser_in = loopMode ? ser_out : serInDrv;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(WIDTH), .IDLE_LEVEL(IDLE_LEVEL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .ser_out    (ser_out),
        .ser_in     (ser_in),
        .shift_en   (shift_en),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .parity_err (parity_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " shift_en"}, shift_en, 0);
        checkOutput({tag, " out_valid"}, out_valid, 0);
        checkOutput({tag, " ser_out"}, ser_out, IDLE_LEVEL);
        checkOutput({tag, " out_data"}, out_data, 0);
        checkOutput({tag, " parity_err"}, parity_err, 0);
    endtask

    // mode: 0 = ser_in held low, 1 = loopback of the model's line bits, 2 = random ser_in
    task automatic applyStimulus(input logic [WIDTH-1:0] word, input int mode,
                                 input int stallCycles, input bit flipParity);
        logic [WIDTH:0]   lineBits;
        logic [WIDTH:0]   rxBits;
        logic [WIDTH-1:0] expData;
        logic             expPerr;
        int               waitCycles;

        lineBits = {^word, word};
        rxBits   = '0;
        waitCycles = 0;
        while (!in_ready && waitCycles < 20) begin
            stepClk();
            waitCycles++;
        end
        checkOutput("in_ready before accept", in_ready, 1);

        in_valid  = 1'b1;
        in_data   = word;
        out_ready = 1'b0;
        stepClk();
        in_data = ~word;

        for (int i = 0; i < NSHIFT; i++) begin
            checkOutput($sformatf("shift_en cycle %0d", i), shift_en, 1);
            checkOutput($sformatf("in_ready cycle %0d", i), in_ready, 0);
            checkOutput($sformatf("out_valid cycle %0d", i), out_valid, 0);
            checkOutput($sformatf("ser_out bit %0d of %0h", i, word), ser_out, lineBits[i]);
            case (mode)
                0:       rxBits[i] = 1'b0;
                1:       rxBits[i] = lineBits[i];
                default: rxBits[i] = 1'($urandom_range(0, 1));
            endcase
            if (flipParity && i == WIDTH) rxBits[i] = ~rxBits[i];
            serInDrv = rxBits[i];
            stepClk();
        end

        expData = rxBits[WIDTH-1:0];
`ifdef SHIFT_PARITY_EN
        expPerr = rxBits[WIDTH] ^ (^expData);
`else
        expPerr = 1'b0;
`endif
        checkOutput("out_valid in hold", out_valid, 1);
        checkOutput($sformatf("out_data for %0h", word), out_data, expData);
        if (mode == 1) checkOutput("loopback word", out_data, word);
        checkOutput("shift_en in hold", shift_en, 0);
        checkOutput("busy in hold", busy, 1);
        checkOutput("ser_out idle in hold", ser_out, IDLE_LEVEL);
        checkOutput("parity_err in hold", parity_err, expPerr);
        checkOutput("in_ready in hold", in_ready, 0);

        for (int s = 0; s < stallCycles; s++) begin
            stepClk();
            checkOutput($sformatf("stall %0d out_valid", s), out_valid, 1);
            checkOutput($sformatf("stall %0d out_data", s), out_data, expData);
            checkOutput($sformatf("stall %0d in_ready", s), in_ready, 0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        stepClk();
        out_ready = 1'b0;
        checkOutput("out_valid after release", out_valid, 0);
        checkOutput("busy after release", busy, 0);
        checkOutput("in_ready after release", in_ready, 1);
        checkOutput("parity_err after release", parity_err, 0);
    endtask

    initial begin
        logic [WIDTH-1:0] words[3];
        logic [WIDTH-1:0] got[$];
        int               accepts[$];
        int               cyc;
        int               idx;
        bit               accepted;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        serInDrv  = 1'b0;
        loopMode  = 1'b0;
        stepClk();
        stepClk();
        checkResetOutputs("initial reset");
        checkOutput("in_ready during reset", in_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", in_ready, 1);

        $display("[TB] loopback 0xA5");
        applyStimulus(8'hA5, 1, 0, 1'b0);

        $display("[TB] 0xFF with ser_in low");
        applyStimulus(8'hFF, 0, 0, 1'b0);

        $display("[TB] backpressure for 20 cycles");
        applyStimulus(8'h96, 1, 20, 1'b0);

        $display("[TB] reset mid-transfer");
        in_valid = 1'b1;
        in_data  = 8'h5A;
        stepClk();
        for (int i = 0; i < 3; i++) begin
            serInDrv = 1'($urandom_range(0, 1));
            stepClk();
        end
        rst = 1'b1;
        stepClk();
        checkResetOutputs("mid-transfer reset");
        checkOutput("in_ready with rst", in_ready, 0);
        stepClk();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("no accept under rst", busy, 0);
        checkOutput("in_ready after mid reset", in_ready, 1);
        applyStimulus(8'h3C, 1, 0, 1'b0);

        $display("[TB] random transfers");
        for (int r = 0; r < 6; r++) begin
            applyStimulus(WIDTH'($urandom), (r % 3 == 0) ? 1 : 2, $urandom_range(0, 3), 1'b0);
        end

`ifdef SHIFT_PARITY_EN
        $display("[TB] parity transfers");
        applyStimulus(8'h07, 1, 0, 1'b0);
        applyStimulus(8'h07, 1, 0, 1'b1);
`endif

        $display("[TB] back-to-back loopback");
        words[0]  = 8'h01;
        words[1]  = 8'h02;
        words[2]  = 8'h03;
        loopMode  = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = words[0];
        idx = 0;
        cyc = 0;
        while (cyc < 60 && got.size() < 3) begin
            accepted = in_valid && in_ready;
            if (accepted) accepts.push_back(cyc);
            if (out_valid) got.push_back(out_data);
            stepClk();
            cyc++;
            if (accepted) begin
                idx++;
                if (idx < 3) in_data = words[idx];
                else in_valid = 1'b0;
            end
        end
        checkOutput("b2b word count", got.size(), 3);
        checkOutput("b2b accept count", accepts.size(), 3);
        for (int k = 0; k < got.size() && k < 3; k++) begin
            checkOutput($sformatf("b2b word %0d", k), got[k], words[k]);
        end
        for (int k = 1; k < accepts.size(); k++) begin
            checkOutput($sformatf("b2b spacing %0d", k), accepts[k] - accepts[k-1], NSHIFT + 2);
        end
        loopMode  = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        stepClk();
        checkOutput("idle after b2b", busy, 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
